ltl_nfa_monitor: RTL and testbench

LTL_NFA_MONITOR -- requirements
Module: ltl_nfa_monitor

---
 rtl/ltl_mon_pkg.sv | 20 ++
 rtl/ltl_ste_cell.sv | 61 ++++++
 rtl/ltl_nfa_monitor.sv | 124 ++++++++++++
 tb/tb_ltl_nfa_monitor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ltl_mon_pkg.sv
// Shared types and constants for the NFA-based stream monitor.
package ltl_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_STREAM = 2'd2,
    ST_HALT   = 2'd3
  } mon_state_t;

  localparam logic [1:0] CFG_MATCH  = 2'd0;
  localparam logic [1:0] CFG_EDGE   = 2'd1;
  localparam logic [1:0] CFG_START  = 2'd2;
  localparam logic [1:0] CFG_REPORT = 2'd3;

  localparam logic [1:0] START_NONE = 2'd0;
  localparam logic [1:0] START_SOD  = 2'd1;
  localparam logic [1:0] START_ALL  = 2'd2;

endpackage

// File: rtl/ltl_ste_cell.sv
// One state-transition element: symbol match table, incoming edge row,
// start type, report enable and the active flop.
module ltl_ste_cell
  import ltl_mon_pkg::*;
#(
  parameter int unsigned N_STATES = 16,
  parameter int unsigned SYM_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        step,
  input  logic                        armed,
  input  logic                        match_we,
  input  logic                        edge_we,
  input  logic                        start_we,
  input  logic                        report_we,
  input  logic [SYM_W-1:0]            cfg_sym,
  input  logic [$clog2(N_STATES)-1:0] cfg_src,
  input  logic [1:0]                  cfg_data,
  input  logic [SYM_W-1:0]            sym,
  input  logic [N_STATES-1:0]         active_vec,
  output logic                        active,
  output logic                        active_nxt,
  output logic                        report_en
);

  logic [2**SYM_W-1:0] match_tbl;
  logic [N_STATES-1:0] edge_row;
  logic [1:0]          start_type;

  always_ff @(posedge clk) begin
    if (reset) begin
      match_tbl  <= '0;
      edge_row   <= '0;
      start_type <= START_NONE;
      report_en  <= 1'b0;
    end else begin
      if (match_we)  match_tbl[cfg_sym] <= cfg_data[0];
      if (edge_we)   edge_row[cfg_src]  <= cfg_data[0];
      if (start_we)  start_type         <= cfg_data;
      if (report_we) report_en          <= cfg_data[0];
    end
  end

  always_comb begin
    active_nxt = match_tbl[sym] &&
                 ((|(edge_row & active_vec)) ||
                  (start_type == START_SOD && armed) ||
                  (start_type == START_ALL));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      active <= 1'b0;
    end else if (step) begin
      active <= active_nxt;
    end
  end

endmodule

// File: rtl/ltl_nfa_monitor.sv
// Homogeneous-NFA stream monitor: an array of STEs stepped once per accepted
// symbol, with report capture, counters and a small stream-control FSM.
module ltl_nfa_monitor
  import ltl_mon_pkg::*;
#(
  parameter int unsigned N_STATES = 16,
  parameter int unsigned SYM_W    = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_we,
  input  logic [1:0]                  cfg_type,
  input  logic [$clog2(N_STATES)-1:0] cfg_row,
  input  logic [((SYM_W > $clog2(N_STATES)) ? SYM_W : $clog2(N_STATES))-1:0] cfg_col,
  input  logic [1:0]                  cfg_data,
  input  logic                        start,
  input  logic                        stop_on_report,
  input  logic                        sym_valid,
  input  logic [SYM_W-1:0]            sym,
  output logic                        sym_ready,
  output logic [N_STATES-1:0]         report_vec,
  output logic                        report_any,
  output logic [CNT_W-1:0]            report_cnt,
  output logic [CNT_W-1:0]            first_idx,
  output logic                        first_valid,
  output logic [CNT_W-1:0]            sym_cnt,
  output logic                        busy
);

  localparam int unsigned RW        = $clog2(N_STATES);
  localparam int unsigned SYM_DEPTH = 2**SYM_W;

  mon_state_t          state, state_nxt;
  logic                accept;
  logic                cfg_ok, col_sym_ok, col_src_ok;
  logic [N_STATES-1:0] active, active_nxt, report_en, hit_vec;
  logic                hit_any;

  assign cfg_ok     = cfg_we && (state == ST_IDLE || state == ST_HALT) &&
                      (32'(cfg_row) < N_STATES);
  assign col_sym_ok = 32'(cfg_col) < SYM_DEPTH;
  assign col_src_ok = 32'(cfg_col) < N_STATES;

  for (genvar i = 0; i < N_STATES; i++) begin : g_ste
    logic row_sel;
    assign row_sel    = cfg_ok && (32'(cfg_row) == i);
    assign hit_vec[i] = active_nxt[i] & report_en[i];

    ltl_ste_cell #(
      .N_STATES(N_STATES),
      .SYM_W   (SYM_W)
    ) u_ste (
      .clk       (clk),
      .reset     (reset),
      .clear     (start),
      .step      (accept),
      .armed     (state == ST_ARMED),
      .match_we  (row_sel && cfg_type == CFG_MATCH && col_sym_ok),
      .edge_we   (row_sel && cfg_type == CFG_EDGE && col_src_ok),
      .start_we  (row_sel && cfg_type == CFG_START),
      .report_we (row_sel && cfg_type == CFG_REPORT),
      .cfg_sym   (cfg_col[SYM_W-1:0]),
      .cfg_src   (cfg_col[RW-1:0]),
      .cfg_data  (cfg_data),
      .sym       (sym),
      .active_vec(active),
      .active    (active[i]),
      .active_nxt(active_nxt[i]),
      .report_en (report_en[i])
    );
  end

  assign hit_any = |hit_vec;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // A start pulse takes priority over any symbol presented in the same cycle.
  // Halting uses the combinational hit so the very next symbol is refused.
  always_comb begin
    state_nxt = state;
    sym_ready = (state == ST_ARMED) || (state == ST_STREAM);
    accept    = sym_valid && sym_ready && !start;
    if (start) begin
      state_nxt = ST_ARMED;
    end else begin
      case (state)
        ST_ARMED, ST_STREAM: begin
          if (accept) state_nxt = (stop_on_report && hit_any) ? ST_HALT : ST_STREAM;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      report_vec  <= '0;
      report_cnt  <= '0;
      sym_cnt     <= '0;
      first_idx   <= '0;
      first_valid <= 1'b0;
    end else if (accept) begin
      report_vec <= hit_vec;
      if (sym_cnt != '1) sym_cnt <= sym_cnt + 1'b1;
      if (hit_any) begin
        if (report_cnt != '1) report_cnt <= report_cnt + 1'b1;
        if (!first_valid) begin
          first_valid <= 1'b1;
          first_idx   <= sym_cnt;
        end
      end
    end else if (state != ST_HALT) begin
      report_vec <= '0;
    end
  end

  assign report_any = |report_vec;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_ltl_nfa_monitor.sv
// Self-checking bench for ltl_nfa_monitor: table-driven streams with a
// report scoreboard plus hand-written halt, reset and saturation sequences.
module tb_ltl_nfa_monitor;
  import ltl_mon_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_type = '0;
  logic [3:0]  cfg_row = '0;
  logic [7:0]  cfg_col = '0;
  logic [1:0]  cfg_data = '0;
  logic        start = 1'b0, stop_on_report = 1'b0, sym_valid = 1'b0;
  logic [7:0]  sym = '0;
  logic        sym_ready, report_any, first_valid, busy;
  logic [15:0] report_vec, report_cnt, first_idx, sym_cnt;

  ltl_nfa_monitor #(.N_STATES(16), .SYM_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_type(cfg_type),
    .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_data(cfg_data),
    .start(start), .stop_on_report(stop_on_report), .sym_valid(sym_valid),
    .sym(sym), .sym_ready(sym_ready), .report_vec(report_vec),
    .report_any(report_any), .report_cnt(report_cnt), .first_idx(first_idx),
    .first_valid(first_valid), .sym_cnt(sym_cnt), .busy(busy)
  );

  // Small instance for counter saturation.
  logic       cfg_we1 = 1'b0;
  logic [1:0] cfg_type1 = '0;
  logic [0:0] cfg_row1 = '0;
  logic [3:0] cfg_col1 = '0;
  logic [1:0] cfg_data1 = '0;
  logic       start1 = 1'b0, sym_valid1 = 1'b0;
  logic [3:0] sym1 = '0;
  logic       sym_ready1, report_any1, first_valid1, busy1;
  logic [1:0] report_vec1, report_cnt1, first_idx1, sym_cnt1;

  ltl_nfa_monitor #(.N_STATES(2), .SYM_W(4), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .cfg_we(cfg_we1), .cfg_type(cfg_type1),
    .cfg_row(cfg_row1), .cfg_col(cfg_col1), .cfg_data(cfg_data1),
    .start(start1), .stop_on_report(1'b0), .sym_valid(sym_valid1),
    .sym(sym1), .sym_ready(sym_ready1), .report_vec(report_vec1),
    .report_any(report_any1), .report_cnt(report_cnt1), .first_idx(first_idx1),
    .first_valid(first_valid1), .sym_cnt(sym_cnt1), .busy(busy1)
  );

  int total = 0;
  int passed = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    int sym;
    int exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] t, input int row, input int col, input int d);
    cfg_we = 1'b1; cfg_type = t; cfg_row = 4'(row); cfg_col = 8'(col); cfg_data = 2'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_report();
    logic [15:0] e;
    e = exp_q.pop_front();
    chk("report_vec", 32'(report_vec), 32'(e));
    chk("report_any", 32'(report_any), 32'(|e));
  endtask

  task automatic send(input int s, input int exp);
    sym_valid = 1'b1;
    sym = 8'(s);
    exp_q.push_back(16'(exp));
    tick();
    sym_valid = 1'b0;
    check_report();
  endtask

  initial begin
    tbl[0] = '{sym: 0,  exp: 0};
    tbl[1] = '{sym: 5,  exp: 2};
    tbl[2] = '{sym: 1,  exp: 0};
    tbl[3] = '{sym: 5,  exp: 0};
    tbl[4] = '{sym: 15, exp: 1};
    tbl[5] = '{sym: 3,  exp: 0};
    tbl[6] = '{sym: 15, exp: 1};
    tbl[7] = '{sym: 15, exp: 1};

    do_reset();
    chk("rst_report_vec", 32'(report_vec), 0);
    chk("rst_report_cnt", 32'(report_cnt), 0);
    chk("rst_sym_cnt", 32'(sym_cnt), 0);
    chk("rst_first_valid", 32'(first_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sym_ready", 32'(sym_ready), 0);

    // Two-STE chain: STE0 start-of-data on {0,2,8,10}, STE1 <- STE0 on 4..7.
    foreach (tbl[k]) if (k < 0) $display("unreachable");
    for (int s = 0; s < 16; s += 2) if (s == 0 || s == 2 || s == 8 || s == 10) cfg(CFG_MATCH, 0, s, 1);
    cfg(CFG_START, 0, 0, 1);
    for (int s = 4; s < 8; s++) cfg(CFG_MATCH, 1, s, 1);
    cfg(CFG_EDGE, 1, 0, 1);
    cfg(CFG_REPORT, 1, 0, 1);

    start = 1'b1; sym_valid = 1'b1; sym = 8'd0;
    tick();
    start = 1'b0; sym_valid = 1'b0;
    chk("start_sym_not_accepted", 32'(sym_cnt), 0);
    chk("armed_busy", 32'(busy), 1);
    chk("armed_sym_ready", 32'(sym_ready), 1);

    for (int i = 0; i < 2; i++) send(tbl[i].sym, tbl[i].exp);
    chk("t1_first_valid", 32'(first_valid), 1);
    chk("t1_first_idx", 32'(first_idx), 1);
    chk("t1_report_cnt", 32'(report_cnt), 1);
    chk("t1_sym_cnt", 32'(sym_cnt), 2);
    tick();
    chk("idle_report_clear", 32'(report_vec), 0);

    pulse_start();
    chk("start_clears_first_valid", 32'(first_valid), 0);
    for (int i = 2; i < 4; i++) send(tbl[i].sym, tbl[i].exp);
    chk("t2_report_cnt", 32'(report_cnt), 0);
    chk("t2_sym_cnt", 32'(sym_cnt), 2);
    chk("t2_first_valid", 32'(first_valid), 0);

    // All-input STE0 on symbol 15, reporting.
    do_reset();
    cfg(CFG_MATCH, 0, 15, 1);
    cfg(CFG_START, 0, 0, 2);
    cfg(CFG_REPORT, 0, 0, 1);
    pulse_start();
    for (int i = 4; i < 8; i++) send(tbl[i].sym, tbl[i].exp);
    chk("t3_report_cnt", 32'(report_cnt), 3);
    chk("t3_first_idx", 32'(first_idx), 0);
    chk("t3_sym_cnt", 32'(sym_cnt), 4);
    cfg(CFG_MATCH, 0, 5, 1);
    send(5, 0);

    // Stop on first report.
    stop_on_report = 1'b1;
    pulse_start();
    send(15, 1);
    chk("halt_sym_ready", 32'(sym_ready), 0);
    chk("halt_busy", 32'(busy), 1);
    sym_valid = 1'b1; sym = 8'd15;
    tick();
    sym_valid = 1'b0;
    chk("halt_report_hold", 32'(report_vec), 1);
    chk("halt_report_cnt", 32'(report_cnt), 1);
    chk("halt_sym_cnt", 32'(sym_cnt), 1);

    // Config in HALT is accepted; out-of-range edge source is ignored.
    cfg(CFG_MATCH, 0, 3, 1);
    cfg(CFG_MATCH, 1, 3, 1);
    cfg(CFG_REPORT, 1, 0, 1);
    cfg(CFG_EDGE, 1, 16, 1);
    stop_on_report = 1'b0;
    pulse_start();
    send(3, 1);
    send(3, 1);

    // Reset mid-stream discards stream and configuration.
    pulse_start();
    send(15, 1);
    reset = 1'b1; sym_valid = 1'b1; sym = 8'd15;
    tick();
    reset = 1'b0; sym_valid = 1'b0;
    chk("mid_rst_report_vec", 32'(report_vec), 0);
    chk("mid_rst_report_any", 32'(report_any), 0);
    chk("mid_rst_report_cnt", 32'(report_cnt), 0);
    chk("mid_rst_sym_cnt", 32'(sym_cnt), 0);
    chk("mid_rst_first_valid", 32'(first_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    pulse_start();
    send(15, 0);
    send(3, 0);
    chk("post_rst_report_cnt", 32'(report_cnt), 0);

    // Saturation: self-looping reporting STE matching every symbol, CNT_W=2.
    for (int s = 0; s < 16; s++) begin
      cfg_we1 = 1'b1; cfg_type1 = CFG_MATCH; cfg_row1 = 1'b0; cfg_col1 = 4'(s); cfg_data1 = 2'd1;
      tick();
    end
    cfg_type1 = CFG_START; cfg_data1 = 2'd1; tick();
    cfg_type1 = CFG_EDGE;  cfg_col1 = 4'd0; cfg_data1 = 2'd1; tick();
    cfg_type1 = CFG_REPORT; cfg_data1 = 2'd1; tick();
    cfg_we1 = 1'b0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sym_valid1 = 1'b1; sym1 = 4'(i * 3);
      tick();
      chk("sat_report_vec", 32'(report_vec1), 1);
    end
    sym_valid1 = 1'b0;
    chk("sat_report_cnt", 32'(report_cnt1), 3);
    chk("sat_sym_cnt", 32'(sym_cnt1), 3);
    chk("sat_first_idx", 32'(first_idx1), 0);
    chk("sat_first_valid", 32'(first_valid1), 1);
    chk("sat_busy", 32'(busy1), 1);
    chk("sat_sym_ready", 32'(sym_ready1), 1);
    chk("sat_report_any", 32'(report_any1), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
